mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Optional round-robin arbitration is selected with MEM_ARB_RR_EN.
package mem_arb_pkg;

   localparam int unsigned MEM_ADDR_W = 28;
   localparam int unsigned MEM_DATA_W = 128;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_e;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the I-cache and D-cache requests.
// MEM_ARB_RR_EN: ties alternate against last_grant; otherwise the D-cache wins ties.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic ic_req,
   input  logic dc_req,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant
);

`ifndef MEM_ARB_RR_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      grant_valid = ic_req | dc_req;
      grant       = PORT_D;
      if (ic_req && dc_req) begin
`ifdef MEM_ARB_RR_EN
         grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
`else
         grant = PORT_D;
`endif
      end else if (ic_req) begin
         grant = PORT_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter merging I-cache and D-cache block ports onto one memory port.
// Arbitration policy is fixed-priority (D wins) unless MEM_ARB_RR_EN is defined.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = MEM_ADDR_W,
   parameter int unsigned DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              ic_mem_read,
   input  logic              ic_mem_write,
   input  logic [ADDR_W-1:0] ic_mem_addr,
   input  logic [DATA_W-1:0] ic_mem_wdata,
   output logic [DATA_W-1:0] ic_mem_rdata,
   output logic              ic_mem_ready,
   input  logic              dc_mem_read,
   input  logic              dc_mem_write,
   input  logic [ADDR_W-1:0] dc_mem_addr,
   input  logic [DATA_W-1:0] dc_mem_wdata,
   output logic [DATA_W-1:0] dc_mem_rdata,
   output logic              dc_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   state_e state_q, state_d;
   logic   last_grant_q;
   logic   grant_valid, grant;
   logic   load, done;

   logic              sel_read, sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              ic_own, dc_own;

   mem_arb_pick u_pick (
      .ic_req      (ic_mem_read | ic_mem_write),
      .dc_req      (dc_mem_read | dc_mem_write),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   assign sel_read  = (grant == PORT_D) ? dc_mem_read  : ic_mem_read;
   assign sel_write = (grant == PORT_D) ? dc_mem_write : ic_mem_write;
   assign sel_addr  = (grant == PORT_D) ? dc_mem_addr  : ic_mem_addr;
   assign sel_wdata = (grant == PORT_D) ? dc_mem_wdata : ic_mem_wdata;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (grant_valid) begin
               load    = 1'b1;
               state_d = (grant == PORT_D) ? S_BUSY_D : S_BUSY_I;
            end
         end
         S_BUSY_I, S_BUSY_D: begin
            if (mem_ready) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= PORT_I;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_write <= sel_write;
            // A read+write collision forwards only the write.
            mem_read  <= sel_read & ~sel_write;
         end else if (done) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            last_grant_q <= (state_q == S_BUSY_D) ? PORT_D : PORT_I;
         end
      end
   end

   // Reset abandons an in-flight transaction without completing it to the cache.
   assign ic_own = (state_q == S_BUSY_I) && !proc_reset;
   assign dc_own = (state_q == S_BUSY_D) && !proc_reset;

   assign ic_mem_ready = ic_own & mem_ready;
   assign dc_mem_ready = dc_own & mem_ready;
   assign ic_mem_rdata = ic_own ? mem_rdata : '0;
   assign dc_mem_rdata = dc_own ? mem_rdata : '0;

endmodule
